dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port `data_memory` between the CPU datapath and a DMA/debug requester (program loader, memory inspector). CPU owns the port by default. The DMA side wins ownership through a req/gnt handshake, moves a burst of beats, then hands the port back. While DMA owns the port, the arbiter drives `cpu_stall` so the PC and register loads freeze.

## Interface
- `ADDR_W`, 8, address width (matches the `data_memory` address).
- `DATA_W`, 8, data width.
- `MAX_BURST`, 4, max DMA beats per grant when the burst limit is compiled in; must be ≥1.
- `MIN_CPU`, 2, guaranteed CPU-owned cycles before any (re)grant; must be ≥1.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cpu_req` in 1: CPU memory access this cycle.
- `cpu_we` in 1: CPU write enable.
- `cpu_addr` in ADDR_W: CPU address.
- `cpu_wdata` in DATA_W: CPU write data (register B).
- `cpu_stall` out 1: CPU must hold PC, LA, LB and `mem_we`.
- `cpu_rdata` out DATA_W: read data to the CPU.
- `dma_req` in 1: DMA beat request; held high for the whole burst.
- `dma_we` in 1: DMA write enable.
- `dma_addr` in ADDR_W: DMA address.
- `dma_wdata` in DATA_W: DMA write data.
- `dma_last` in 1: the current beat is the final one.
- `dma_gnt` out 1: DMA owns the port (registered).
- `dma_ack` out 1: the current beat is accepted this cycle.
- `dma_rdata` out DATA_W: read data to DMA.
- `mem_addr` out ADDR_W: address to `data_memory`.
- `mem_wdata` out DATA_W: write data to `data_memory`.
- `mem_we` out 1: write enable to `data_memory`.
- `mem_rdata` in DATA_W: combinational read data from `data_memory`.
- `owner` out 1: current owner; 0 = CPU, 1 = DMA.

## Operation
- **States:** CPU_OWN and DMA_XFER. Internal counters:
  - `cpu_cnt`: saturates at MIN_CPU.
  - `beat_cnt`: width clog2(MAX_BURST+1).
- **CPU_OWN:**
  - Port muxed to the CPU: `mem_addr`=`cpu_addr`, `mem_wdata`=`cpu_wdata`, `mem_we`=`cpu_req & cpu_we`.
  - `cpu_stall`=0, `dma_gnt`=0, `dma_ack`=0.
  - `cpu_cnt` increments each cycle, saturating.
- **CPU_OWN → DMA_XFER:** at the edge where `dma_req`=1 and `cpu_cnt`≥MIN_CPU. That edge clears `beat_cnt`.
- **DMA_XFER:**
  - Port muxed to DMA. `dma_gnt`=1, `cpu_stall`=1, `owner`=1.
  - `dma_ack` = `dma_req` (combinational).
  - `mem_we` = `dma_req & dma_we`.
  - Each acked beat increments `beat_cnt`.
- **DMA_XFER → CPU_OWN:** at the edge ending any of these beats:
  - an acked beat with `dma_last`=1;
  - the acked beat that makes `beat_cnt`=MAX_BURST (only with the burst limit compiled in);
  - a cycle with `dma_req`=0. That cycle produces no ack and no write.
- The exit edge clears `cpu_cnt`.
- Simultaneous `dma_last` and burst limit: a single exit.
- `cpu_rdata` = `dma_rdata` = `mem_rdata` at all times. Each consumer qualifies by ownership.
- CPU requests during DMA_XFER are not queued. The CPU re-presents them after `cpu_stall` drops.
- **Reset:** state CPU_OWN, `cpu_cnt`=0, `beat_cnt`=0.
  - During `rst`: `dma_gnt`=0, `dma_ack`=0, `cpu_stall`=0, `owner`=0, `mem_we`=0, regardless of inputs.
- **Reset mid-burst:**
  - `dma_gnt` and `mem_we` drop asynchronously and the burst is abandoned.
  - Beats committed at earlier edges remain in memory.
  - DMA must re-request.

## Timing
- Grant latency: `dma_req` high at edge N (with `cpu_cnt` satisfied) → `dma_gnt`=1 during cycle N+1.
- First grant after reset: no earlier than MIN_CPU+1 cycles.
- Beat throughput: 1 beat per cycle. A write commits at the rising edge that closes the acked cycle. Read data is valid in the acked cycle.
- Release: `dma_gnt` and `cpu_stall` are low the cycle after the exit edge.
- Re-grant gap: CPU then owns the port for ≥MIN_CPU cycles.

## Configuration
- `DMEM_ARB_BURST_LIMIT_EN` defined:
  - A grant ends after MAX_BURST acked beats even without `dma_last`.
  - DMA keeps `dma_req` high and is re-granted after MIN_CPU CPU cycles.
- Undefined:
  - MAX_BURST is ignored; `beat_cnt` still counts.
  - The grant lasts until `dma_last` or `dma_req` drops.

## Test plan
- **Reset:** `rst`=1 with `cpu_req`=`cpu_we`=1, `dma_req`=1 → `mem_we`=0, `dma_gnt`=0, `dma_ack`=0, `cpu_stall`=0, `owner`=0.
- **CPU write/read:** `cpu_we`=1, addr 0x10, data 0x5A → `mem_we`=1, `mem_addr`=0x10. Then a read at 0x10 → `cpu_rdata`=0x5A.
- **DMA burst:** 3-beat write burst to 0x20..0x22 (0x11, 0x22, 0x33), `dma_last` on beat 3, MIN_CPU=2 satisfied →
  - `dma_gnt` rises one cycle after `dma_req`;
  - 3 consecutive acks with `cpu_stall`=1;
  - `dma_gnt` low the next cycle;
  - CPU reads back 0x11, 0x22, 0x33.
- **Burst limit:** MAX_BURST=4, 6-beat burst with no early `dma_last`.
  - Defined: 4 acks, then `dma_gnt` low exactly 2 cycles, then re-grant and 2 acks.
  - Undefined: 6 contiguous acks.
- **Reset mid-burst:** `rst` pulsed after beat 2 of a 4-beat write → `dma_gnt` and `mem_we` drop immediately; only beats 1–2 are present in memory.
- **Requester drop:** `dma_req` deasserted mid-burst → no ack and no write that cycle; `owner`=0 the next cycle; re-grant no earlier than 2 cycles later.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// CPU / DMA / data_memory signal bundle for dmem_arbiter.
// slave = arbiter side, master = requesters plus memory model.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_last;
  logic              dma_gnt;
  logic              dma_ack;
  logic [DATA_W-1:0] dma_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic              owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_last,
    input  mem_rdata,
    output cpu_stall, cpu_rdata, dma_gnt, dma_ack, dma_rdata,
    output mem_addr, mem_wdata, mem_we, owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_last,
    output mem_rdata,
    input  cpu_stall, cpu_rdata, dma_gnt, dma_ack, dma_rdata,
    input  mem_addr, mem_wdata, mem_we, owner
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data_memory arbiter: CPU owns by default, DMA bursts via req/gnt.
// Define DMEM_ARB_BURST_LIMIT_EN to end each grant after MAX_BURST acked beats.
module dmem_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int MIN_CPU   = 2
) (
  input  logic clk,
  input  logic rst,
  dmem_arbiter_if.slave bus
);
  localparam int CNT_W  = $clog2(MIN_CPU + 1);
  localparam int BEAT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {CPU_OWN, DMA_XFER} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cpu_cnt_q, cpu_cnt_d, cpu_cnt_inc;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d, beat_inc;
  logic              burst_done;
  logic              dma_xfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CPU_OWN;
      cpu_cnt_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cpu_cnt_q  <= cpu_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // The current CPU cycle counts toward MIN_CPU, giving a MIN_CPU-cycle re-grant gap.
  always_comb begin
    state_d     = state_q;
    cpu_cnt_d   = cpu_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    cpu_cnt_inc = (cpu_cnt_q == CNT_W'(MIN_CPU)) ? cpu_cnt_q : cpu_cnt_q + 1'b1;
    beat_inc    = beat_cnt_q + 1'b1;
`ifdef DMEM_ARB_BURST_LIMIT_EN
    burst_done  = (beat_inc == BEAT_W'(MAX_BURST));
`else
    burst_done  = 1'b0;
`endif
    case (state_q)
      CPU_OWN: begin
        cpu_cnt_d = cpu_cnt_inc;
        if (bus.dma_req && (cpu_cnt_inc == CNT_W'(MIN_CPU))) begin
          state_d    = DMA_XFER;
          beat_cnt_d = '0;
        end
      end
      DMA_XFER: begin
        if (!bus.dma_req) begin
          state_d   = CPU_OWN;
          cpu_cnt_d = '0;
        end else begin
          beat_cnt_d = beat_inc;
          if (bus.dma_last || burst_done) begin
            state_d   = CPU_OWN;
            cpu_cnt_d = '0;
          end
        end
      end
      default: state_d = CPU_OWN;
    endcase
  end

  assign dma_xfer = (state_q == DMA_XFER);

  assign bus.dma_gnt   = dma_xfer;
  assign bus.cpu_stall = dma_xfer;
  assign bus.owner     = dma_xfer;
  assign bus.dma_ack   = dma_xfer & bus.dma_req & ~rst;

  assign bus.mem_addr  = dma_xfer ? bus.dma_addr  : bus.cpu_addr;
  assign bus.mem_wdata = dma_xfer ? bus.dma_wdata : bus.cpu_wdata;
  // Write enable is forced low while rst is held, whatever the requesters do.
  assign bus.mem_we    = ~rst & (dma_xfer ? (bus.dma_req & bus.dma_we)
                                          : (bus.cpu_req & bus.cpu_we));

  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.dma_rdata = bus.mem_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a cycle-level ownership model.
module tb_dmem_arbiter;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;
  localparam int MIN_CPU   = 2;
`ifdef DMEM_ARB_BURST_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .MIN_CPU(MIN_CPU)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [DATA_W-1:0] mem     [256];
  logic [DATA_W-1:0] ref_mem [256];

  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the port, CPU cycles since release, beats this grant.
  bit m_owner;
  int m_cpu;
  int m_beats;
  bit exp_ack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic observe();
    logic [ADDR_W-1:0] ea;
    bit ewe;
    if (rst) begin
      exp_ack = 1'b0;
      ea = bus.cpu_addr;
      check("rst_gnt",   bus.dma_gnt,   0);
      check("rst_ack",   bus.dma_ack,   0);
      check("rst_stall", bus.cpu_stall, 0);
      check("rst_owner", bus.owner,     0);
      check("rst_we",    bus.mem_we,    0);
    end else begin
      exp_ack = m_owner && bus.dma_req;
      ewe = m_owner ? (bus.dma_req && bus.dma_we) : (bus.cpu_req && bus.cpu_we);
      ea  = m_owner ? bus.dma_addr : bus.cpu_addr;
      check("gnt",   bus.dma_gnt,   m_owner);
      check("stall", bus.cpu_stall, m_owner);
      check("owner", bus.owner,     m_owner);
      check("ack",   bus.dma_ack,   exp_ack);
      check("we",    bus.mem_we,    ewe);
      if (ewe) check("wdata", bus.mem_wdata, m_owner ? bus.dma_wdata : bus.cpu_wdata);
    end
    check("addr",      bus.mem_addr,  ea);
    check("cpu_rdata", bus.cpu_rdata, ref_mem[ea]);
    check("dma_rdata", bus.dma_rdata, ref_mem[ea]);
  endtask

  task automatic model_advance();
    if (rst) begin
      m_owner = 0; m_cpu = 0; m_beats = 0;
    end else if (!m_owner) begin
      if (bus.cpu_req && bus.cpu_we) ref_mem[bus.cpu_addr] = bus.cpu_wdata;
      m_cpu++;
      if (bus.dma_req && m_cpu >= MIN_CPU) begin
        m_owner = 1; m_beats = 0;
      end
    end else if (!bus.dma_req) begin
      m_owner = 0; m_cpu = 0;
    end else begin
      if (bus.dma_we) ref_mem[bus.dma_addr] = bus.dma_wdata;
      m_beats++;
      if (bus.dma_last || (LIMIT && m_beats == MAX_BURST)) begin
        m_owner = 0; m_cpu = 0;
      end
    end
  endtask

  task automatic step();
    #3;
    observe();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.cpu_req = 0; bus.cpu_we = 0; bus.dma_req = 0; bus.dma_last = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cpu_read(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    bus.dma_req = 0; bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = a;
    #2;
    check(tag, bus.cpu_rdata, exp);
    step();
  endtask

  task automatic dma_burst(input logic [ADDR_W-1:0] base, input int n, input bit use_last,
                           input int drop_at, output int gap, output int lat);
    int b;
    bit dropped;
    bit seen;
    b = 0; dropped = 0; seen = 0; gap = 0; lat = -1;
    bus.cpu_req = 0; bus.cpu_we = 0;
    for (int c = 0; c < 60 && b < n; c++) begin
      bit drop;
      drop = (b == drop_at) && !dropped;
      if (drop) dropped = 1;
      bus.dma_req   = !drop;
      bus.dma_we    = 1;
      bus.dma_addr  = base + ADDR_W'(b);
      bus.dma_wdata = DATA_W'(8'h11 * (b + 1));
      bus.dma_last  = use_last && (b == n - 1);
      #3;
      observe();
      if (bus.dma_gnt) begin
        if (!seen) lat = c;
        seen = 1;
      end else if (seen) gap++;
      if (exp_ack) b++;
      model_advance();
      @(posedge clk);
      #1;
    end
    check("burst_beats", b, n);
    bus.dma_req = 0; bus.dma_last = 0;
    step();
  endtask

  int gap, lat;
  int r_left;
  bit r_lastmode;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    m_owner = 0; m_cpu = 0; m_beats = 0; exp_ack = 0;

    // Reset with every request asserted
    rst = 1;
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 8'h05; bus.cpu_wdata = 8'hEE;
    bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 8'h06; bus.dma_wdata = 8'hDD;
    bus.dma_last = 0;
    @(posedge clk); #1;
    step();
    step();
    rst = 0;
    idle(3);

    // CPU write then read back
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 8'h10; bus.cpu_wdata = 8'h5A;
    #2;
    check("cpu_wr_we", bus.mem_we, 1);
    check("cpu_wr_addr", bus.mem_addr, 8'h10);
    step();
    cpu_read("cpu_rd_10", 8'h10, 8'h5A);
    idle(2);

    // 3-beat DMA write burst with dma_last
    dma_burst(8'h20, 3, 1'b1, -1, gap, lat);
    check("b3_latency", lat, 1);
    check("b3_gap", gap, 0);
    cpu_read("b3_rd20", 8'h20, 8'h11);
    cpu_read("b3_rd21", 8'h21, 8'h22);
    cpu_read("b3_rd22", 8'h22, 8'h33);
    idle(2);

    // 6-beat burst without dma_last
    dma_burst(8'h30, 6, 1'b0, -1, gap, lat);
    check("b6_latency", lat, 1);
    check("b6_gap", gap, LIMIT ? 2 : 0);
    cpu_read("b6_rd35", 8'h35, 8'h66);
    idle(2);

    // Requester drop mid-burst
    dma_burst(8'h50, 4, 1'b1, 2, gap, lat);
    check("drop_gap", gap, 2);
    cpu_read("drop_rd52", 8'h52, 8'h33);
    cpu_read("drop_rd53", 8'h53, 8'h44);
    idle(2);

    // Reset pulsed after beat 2 of a 4-beat write
    begin
      int b;
      b = 0;
      bus.cpu_req = 0; bus.cpu_we = 0;
      for (int c = 0; c < 20 && b < 2; c++) begin
        bus.dma_req = 1; bus.dma_we = 1; bus.dma_last = 0;
        bus.dma_addr = 8'h40 + ADDR_W'(b);
        bus.dma_wdata = 8'hA1 + DATA_W'(b);
        #3;
        observe();
        if (exp_ack) b++;
        model_advance();
        @(posedge clk); #1;
      end
      check("mid_beats", b, 2);
      bus.dma_addr = 8'h42; bus.dma_wdata = 8'hA3;
      #1;
      rst = 1;
      #1;
      check("mid_gnt_drop", bus.dma_gnt, 0);
      check("mid_we_drop", bus.mem_we, 0);
      step();
      rst = 0;
      idle(1);
      cpu_read("mid_rd40", 8'h40, 8'hA1);
      cpu_read("mid_rd41", 8'h41, 8'hA2);
      cpu_read("mid_rd42", 8'h42, 8'h00);
    end

    // Randomized traffic against the model
    r_left = 0; r_lastmode = 0;
    for (int c = 0; c < 3000; c++) begin
      bit drop;
      rst = ($urandom_range(299) == 0);
      if (rst) r_left = 0;
      if (r_left == 0 && $urandom_range(7) == 0) begin
        r_left = $urandom_range(6, 1);
        r_lastmode = 1'($urandom_range(1));
      end
      drop = (r_left > 0) && ($urandom_range(15) == 0);
      bus.dma_req   = (r_left > 0) && !drop;
      bus.dma_we    = 1'($urandom_range(1));
      bus.dma_addr  = ADDR_W'($urandom_range(31));
      bus.dma_wdata = DATA_W'($urandom);
      bus.dma_last  = r_lastmode && (r_left == 1);
      bus.cpu_req   = 1'($urandom_range(1));
      bus.cpu_we    = 1'($urandom_range(1));
      bus.cpu_addr  = ADDR_W'($urandom_range(31));
      bus.cpu_wdata = DATA_W'($urandom);
      #3;
      observe();
      if (exp_ack) r_left--;
      model_advance();
      @(posedge clk); #1;
    end
    rst = 0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
